// File: rtl/branch_predict_gshare_pkg.sv
// ----------------------------------------------------------------------------
// branch_predict_gshare_pkg
// Shared definitions for the gshare branch predictor:
//   - 2-bit saturating counter encodings (SNT, WNT, WT, ST)
//   - predictor FSM state codes (ST_INIT, ST_RUN)
//   - default table / history widths
// ----------------------------------------------------------------------------
package branch_predict_gshare_pkg;

    // Two-bit counter encodings; bit 1 is the predicted direction.
    localparam logic [1:0] SNT = 2'b00;   // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;   // weakly not-taken (post-init value)
    localparam logic [1:0] WT  = 2'b10;   // weakly taken
    localparam logic [1:0] ST  = 2'b11;   // strongly taken

    // Predictor control states.
    typedef enum logic {
        ST_INIT = 1'b0,   // sweeping the PHT to WNT, one entry per cycle
        ST_RUN  = 1'b1    // predicting and training
    } state_t;

    // Default widths.
    localparam int PHT_IDX_W_DEF = 10;
    localparam int GHR_W_DEF     = 8;

endpackage

// File: rtl/branch_predict_gshare_sat_counter2.sv
// ----------------------------------------------------------------------------
// branch_predict_gshare_sat_counter2
// Pure next-state function of a 2-bit saturating counter.
// Ports:
//   cnt      in  2  current counter value
//   inc      in  1  1 = step toward ST, 0 = step toward SNT
//   cnt_next out 2  updated value, saturating at SNT and ST
// ----------------------------------------------------------------------------
module branch_predict_gshare_sat_counter2
    import branch_predict_gshare_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        case (cnt)
            SNT:     cnt_next = inc ? WNT : SNT;
            WNT:     cnt_next = inc ? WT  : SNT;
            WT:      cnt_next = inc ? ST  : WNT;
            ST:      cnt_next = inc ? ST  : WT;
            default: cnt_next = cnt;
        endcase
    end

endmodule

// File: rtl/branch_predict_gshare.sv
// ----------------------------------------------------------------------------
// branch_predict_gshare
// Gshare conditional-branch predictor for the 5-stage MIPS core. Predicts in
// decode, trains from the resolved outcome in execute. A speculative GHR is
// shifted on every issued prediction; a committed GHR is shifted on every
// resolve and is used to repair the speculative copy on a mispredict.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ready          high once the PHT sweep after reset has finished
//   pcD, branchD, stallD, flushD   decode-stage instruction info
//   pred_takeD     predicted direction (combinational)
//   pht_idxD       PHT index used for the prediction (pipe to E)
//   branchE, actual_takeE, pred_takeE, pht_idxE   resolved branch info
//   mispredictE    branchE && actual != predicted (combinational)
//
// Optional build macro BPRED_STATS_EN adds 32-bit wrapping counters
// stat_branches and stat_mispredicts (RUN state only, cleared on rst).
// ----------------------------------------------------------------------------
module branch_predict_gshare
    import branch_predict_gshare_pkg::*;
#(
    parameter int PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int GHR_W     = GHR_W_DEF      // 2 <= GHR_W <= PHT_IDX_W
)(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [31:0]          pcD,
    input  logic                 branchD,
    input  logic                 stallD,
    input  logic                 flushD,
    output logic                 pred_takeD,
    output logic [PHT_IDX_W-1:0] pht_idxD,
    input  logic                 branchE,
    input  logic                 actual_takeE,
    input  logic                 pred_takeE,
    input  logic [PHT_IDX_W-1:0] pht_idxE,
    output logic                 mispredictE
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam int PHT_ENTRIES = 1 << PHT_IDX_W;

    state_t               state_reg, state_next;
    logic [PHT_IDX_W-1:0] init_idx_reg, init_idx_next;
    logic [GHR_W-1:0]     spec_ghr_reg, spec_ghr_next;
    logic [GHR_W-1:0]     commit_ghr_reg, commit_ghr_next;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [1:0]           upd_cnt;
    logic                 run;

    // Read asynchronously: the prediction and the read-modify-write of the
    // trained entry both have to complete within a single cycle.
    logic [1:0] pht_mem [PHT_ENTRIES];

    // Only the word-aligned index bits of the PC feed the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcD[31:PHT_IDX_W+2], pcD[1:0]};

    assign run   = (state_reg == ST_RUN);
    assign ready = run;

    // Zero-extend the speculative history up to the index width.
    for (genvar gi = 0; gi < PHT_IDX_W; gi++) begin : g_ghr_ext
        if (gi < GHR_W) begin : g_hist
            assign ghr_ext[gi] = spec_ghr_reg[gi];
        end else begin : g_zero
            assign ghr_ext[gi] = 1'b0;
        end
    end

    assign pht_idxD    = pcD[PHT_IDX_W+1:2] ^ ghr_ext;
    assign pred_takeD  = run && branchD && pht_mem[pht_idxD][1];
    assign mispredictE = branchE && (actual_takeE != pred_takeE);

    branch_predict_gshare_sat_counter2 u_sat (
        .cnt      (pht_mem[pht_idxE]),
        .inc      (actual_takeE),
        .cnt_next (upd_cnt)
    );

    // ------------------------------------------------------------------
    // Control FSM: INIT sweeps every entry once, then RUN forever.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        case (state_reg)
            ST_INIT: begin
                init_idx_next = init_idx_reg + PHT_IDX_W'(1);
                if (&init_idx_reg) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // History registers. A mispredict rebuilds the speculative history from
    // the committed one plus the true outcome; the decode-side shift that
    // might happen in the same cycle is dropped because that instruction
    // is on the wrong path and will be flushed.
    // ------------------------------------------------------------------
    always_comb begin
        spec_ghr_next   = spec_ghr_reg;
        commit_ghr_next = commit_ghr_reg;
        if (run) begin
            if (branchE) begin
                commit_ghr_next = {commit_ghr_reg[GHR_W-2:0], actual_takeE};
            end
            if (mispredictE) begin
                spec_ghr_next = {commit_ghr_reg[GHR_W-2:0], actual_takeE};
            end else if (branchD && !stallD && !flushD) begin
                spec_ghr_next = {spec_ghr_reg[GHR_W-2:0], pred_takeD};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            init_idx_reg   <= '0;
            spec_ghr_reg   <= '0;
            commit_ghr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            init_idx_reg   <= init_idx_next;
            spec_ghr_reg   <= spec_ghr_next;
            commit_ghr_reg <= commit_ghr_next;
        end
    end

    // PHT writes: the init sweep owns the table until RUN; afterwards only
    // resolved branches train it. No reset on the array itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == ST_INIT) begin
                pht_mem[init_idx_reg] <= WNT;
            end else if (branchE) begin
                pht_mem[pht_idxE] <= upd_cnt;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else if (run) begin
            if (branchE) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (mispredictE) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predict_gshare.sv
// ----------------------------------------------------------------------------
// tb_branch_predict_gshare
// Directed bench for branch_predict_gshare with a 16-entry PHT and 4-bit
// history. Expected values are hand-derived per step. Build with
// BPRED_STATS_EN defined to also exercise the statistics counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_predict_gshare;

    localparam int IW = 4;
    localparam int GW = 4;

    logic          clk;
    logic          rst;
    logic          ready;
    logic [31:0]   pcD;
    logic          branchD;
    logic          stallD;
    logic          flushD;
    logic          pred_takeD;
    logic [IW-1:0] pht_idxD;
    logic          branchE;
    logic          actual_takeE;
    logic          pred_takeE;
    logic [IW-1:0] pht_idxE;
    logic          mispredictE;
`ifdef BPRED_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_predict_gshare #(.PHT_IDX_W(IW), .GHR_W(GW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .pcD          (pcD),
        .branchD      (branchD),
        .stallD       (stallD),
        .flushD       (flushD),
        .pred_takeD   (pred_takeD),
        .pht_idxD     (pht_idxD),
        .branchE      (branchE),
        .actual_takeE (actual_takeE),
        .pred_takeE   (pred_takeE),
        .pht_idxE     (pht_idxE),
        .mispredictE  (mispredictE)
`ifdef BPRED_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One resolved branch in E for a single cycle.
    task automatic resolve(input logic [IW-1:0] idx, input logic act, input logic pred);
        pht_idxE     = idx;
        actual_takeE = act;
        pred_takeE   = pred;
        branchE      = 1'b1;
        tick();
        branchE      = 1'b0;
    endtask

    // Combinational look at a prediction without letting it be issued.
    task automatic check_pred(input string tag, input logic [31:0] pc,
                              input logic [IW-1:0] exp_idx, input logic exp_take);
        pcD     = pc;
        branchD = 1'b1;
        #1;
        check({tag, "_idx"}, 32'(pht_idxD), 32'(exp_idx));
        check({tag, "_take"}, 32'(pred_takeD), 32'(exp_take));
        branchD = 1'b0;
        #1;
    endtask

    // Speculative GHR is visible as pht_idxD when the PC index bits are zero.
    task automatic check_ghr(input string tag, input logic [IW-1:0] exp);
        pcD = 32'h0040_0000;
        #1;
        check(tag, 32'(pht_idxD), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; pcD = '0; branchD = 0; stallD = 0; flushD = 0;
        branchE = 0; actual_takeE = 0; pred_takeE = 0; pht_idxE = '0;
        tick();
        tick();
        rst = 1'b0;

        // --- Init sweep: 16 cycles not ready, predictions forced to 0 ---
        for (int i = 0; i < 16; i++) begin
            pcD     = 32'h0040_0000 + 32'(i * 4);
            branchD = 1'b1;
            #1;
            check("init_ready", 32'(ready), 32'd0);
            check("init_pred", 32'(pred_takeD), 32'd0);
            branchD = 1'b0;
            tick();
        end
        check("ready_c17", 32'(ready), 32'd1);
        check_ghr("ghr_after_init", 4'h0);
`ifdef BPRED_STATS_EN
        check("stat_br_init", stat_branches, 32'd0);
        check("stat_mp_init", stat_mispredicts, 32'd0);
`endif

        // --- Branch at 0x00400010: first predict, two taken resolves ---
        pcD = 32'h0040_0010; branchD = 1'b1;
        #1;
        check("p1_idx", 32'(pht_idxD), 32'h4);
        check("p1_take", 32'(pred_takeD), 32'd0);
        tick();                                   // spec shifts in 0
        branchD = 1'b0;
        pht_idxE = 4'h4; actual_takeE = 1'b1; pred_takeE = 1'b0; branchE = 1'b1;
        #1;
        check("r1_mispredict", 32'(mispredictE), 32'd1);
        tick();                                   // entry 4: 01 -> 10
        branchE = 1'b0;
        check_ghr("r1_spec_restored", 4'h1);
        pht_idxE = 4'h4; actual_takeE = 1'b1; pred_takeE = 1'b1; branchE = 1'b1;
        #1;
        check("r2_mispredict", 32'(mispredictE), 32'd0);
        tick();                                   // entry 4: 10 -> 11
        branchE = 1'b0;
        check_pred("p2_same_entry", 32'h0040_0014, 4'h4, 1'b1);  // 5 ^ ghr 1
        check_pred("p2_other_entry", 32'h0040_0000, 4'h1, 1'b0);
`ifdef BPRED_STATS_EN
        check("stat_br_2", stat_branches, 32'd2);
        check("stat_mp_1", stat_mispredicts, 32'd1);
`endif

        // --- Build spec=0x5, commit=0x2 then predict+mispredict together ---
        resolve(4'hF, 1'b0, 1'b0);
        resolve(4'hF, 1'b0, 1'b0);
        resolve(4'hF, 1'b1, 1'b1);
        resolve(4'hF, 1'b0, 1'b0);                // commit = 0010
        resolve(4'hF, 1'b1, 1'b0);                // spec = commit = 0101
        resolve(4'hF, 1'b0, 1'b0);
        resolve(4'hF, 1'b0, 1'b0);
        resolve(4'hF, 1'b1, 1'b1);
        resolve(4'hF, 1'b0, 1'b0);                // commit = 0010, spec holds
        check_ghr("spec_0x5", 4'h5);
        pcD = 32'h0040_0000; branchD = 1'b1;
        pht_idxE = 4'hF; actual_takeE = 1'b1; pred_takeE = 1'b0; branchE = 1'b1;
        #1;
        check("same_cycle_mispredict", 32'(mispredictE), 32'd1);
        tick();
        branchD = 1'b0; branchE = 1'b0;
        check_ghr("recovery_wins", 4'h5);         // not 0xB

        // --- Stall holds history, release shifts exactly once ---
        pcD = 32'h0040_0000; branchD = 1'b1; stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hold", 32'(pht_idxD), 32'h5);
            tick();
        end
        stallD = 1'b0;
        #1;
        check("stall_release_pred", 32'(pred_takeD), 32'd0);
        tick();
        branchD = 1'b0;
        check_ghr("shift_once", 4'hA);
        tick();
        check_ghr("shift_once_hold", 4'hA);
        branchD = 1'b1; flushD = 1'b1;
        tick();
        branchD = 1'b0; flushD = 1'b0;
        check_ghr("flush_hold", 4'hA);

        // --- Saturation at both ends (ghr = 0xA) ---
        for (int i = 0; i < 4; i++) resolve(4'h2, 1'b0, 1'b0);
        check_pred("sat_low", 32'h0040_0020, 4'h2, 1'b0);
        resolve(4'h2, 1'b1, 1'b1);                // 00 -> 01
        check_pred("sat_low_inc", 32'h0040_0020, 4'h2, 1'b0);
        for (int i = 0; i < 4; i++) resolve(4'h3, 1'b1, 1'b1);
        check_pred("sat_high", 32'h0040_0024, 4'h3, 1'b1);
        resolve(4'h3, 1'b0, 1'b0);                // 11 -> 10
        check_pred("sat_high_dec", 32'h0040_0024, 4'h3, 1'b1);

        // --- Reset mid-RUN, then again mid-INIT ---
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check_ghr("rst_spec", 4'h0);
`ifdef BPRED_STATS_EN
        check("stat_br_rst", stat_branches, 32'd0);
        check("stat_mp_rst", stat_mispredicts, 32'd0);
`endif
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("reinit_ready", 32'(ready), 32'd0);
            tick();
        end
        check("reinit_ready_up", 32'(ready), 32'd1);
        check_pred("reinit_e3", 32'h0040_000C, 4'h3, 1'b0);
        check_pred("reinit_e4", 32'h0040_0010, 4'h4, 1'b0);
        resolve(4'h7, 1'b0, 1'b1);                // restores spec from commit
        check_ghr("rst_commit", 4'h0);
        resolve(4'h4, 1'b1, 1'b1);                // 01 -> 10 if reinitialised
        check_pred("reinit_e4_wnt", 32'h0040_0010, 4'h4, 1'b1);
`ifdef BPRED_STATS_EN
        check("stat_br_after", stat_branches, 32'd2);
        check("stat_mp_after", stat_mispredicts, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
